// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command codes, arbiter states and default widths
package sdram_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int BANK_W_DEF = 2;

  // Commands encoded as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_MSET  = 4'b0000;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - requester-side and SDRAM-pin signals of the command arbiter
interface sdram_arbit_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
);

  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              flag_init_end;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;

  modport arbiter (
    input  init_cmd, init_addr, flag_init_end,
    input  aref_req, aref_end, aref_cmd, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_bank, sdram_addr
  );

  modport requester (
    output init_cmd, init_addr, flag_init_end,
    output aref_req, aref_end, aref_cmd, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_bank, sdram_addr
  );

endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - init passthrough, then fixed-priority refresh/write/read command-bus arbiter
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  sdram_arbit_if.arbiter bus
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [3:0]        cmd;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] addr;
  logic              cke;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cke   <= 1'b0;
    end else begin
      state <= state_nxt;
      cke   <= 1'b1;
    end
  end

  // Requests are only sampled in ARBIT, so a grant always ends in one NOP cycle.
  always_comb begin
    state_nxt = state;
    cmd       = CMD_NOP;
    bank      = '0;
    addr      = '0;
    unique case (state)
      ST_INIT: begin
        cmd  = bus.init_cmd;
        addr = bus.init_addr;
        if (bus.flag_init_end) state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (bus.aref_req)    state_nxt = ST_AREF;
        else if (bus.wr_req) state_nxt = ST_WRITE;
        else if (bus.rd_req) state_nxt = ST_READ;
      end
      ST_AREF: begin
        cmd  = bus.aref_cmd;
        addr = bus.aref_addr;
        if (bus.aref_end) state_nxt = ST_ARBIT;
      end
      ST_WRITE: begin
        cmd  = bus.wr_cmd;
        bank = bus.wr_bank;
        addr = bus.wr_addr;
        if (bus.wr_end) state_nxt = ST_ARBIT;
      end
      ST_READ: begin
        cmd  = bus.rd_cmd;
        bank = bus.rd_bank;
        addr = bus.rd_addr;
        if (bus.rd_end) state_nxt = ST_ARBIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign bus.aref_en    = (state == ST_AREF);
  assign bus.wr_en      = (state == ST_WRITE);
  assign bus.rd_en      = (state == ST_READ);
  assign bus.sdram_cke  = cke;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
  assign bus.sdram_bank = bank;
  assign bus.sdram_addr = addr;

endmodule
